// File: rtl/const_bit_extractor.sv
// Repacks DWIDTH-bit FIFO words LSB-first into per-tone groups of 0..MAXB bits
// for the constellation mapper; unused bits carry over to the next tone.
module const_bit_extractor #(
  parameter int DWIDTH = 8,
  parameter int MAXB   = 15,
  parameter int BWIDTH = 4,
  parameter int CWIDTH = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              one_available_i,
  input  logic              two_available_i,
  input  logic [DWIDTH-1:0] fifo_data_i,
  output logic              fifo_re_o,
  input  logic              req_i,
  input  logic [BWIDTH-1:0] bits_i,
  input  logic              flush_i,
  output logic [MAXB-1:0]   data_o,
  output logic              valid_o,
  output logic              busy_o,
  output logic [CWIDTH-1:0] bits_avail_o
);

  localparam int AW = MAXB - 1 + DWIDTH;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_READ, S_CAPT} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [CWIDTH-1:0] cnt_q, cnt_d;
  logic [BWIDTH-1:0] b_q, b_d;
  logic [MAXB-1:0]   data_q, data_d;
  logic              valid_q, valid_d;
  logic              re_q, re_d;
  logic              unused_s;

  // Reserved for a future read-ahead path.
  assign unused_s = two_available_i;

  function automatic logic [AW-1:0] low_mask(input logic [BWIDTH-1:0] n);
    low_mask = (AW'(1) << n) - AW'(1);
  endfunction

  // Next-state and datapath update; flush outranks everything but reset.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    b_d     = b_q;
    data_d  = data_q;
    valid_d = 1'b0;
    re_d    = 1'b0;
    if (flush_i) begin
      state_d = S_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_i) begin
            b_d     = (32'(bits_i) > MAXB) ? BWIDTH'(MAXB) : bits_i;
            state_d = S_CHECK;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_CHECK: begin
          if (cnt_q >= CWIDTH'(b_q)) begin
            data_d  = MAXB'(acc_q & low_mask(b_q));
            acc_d   = acc_q >> b_q;
            cnt_d   = cnt_q - CWIDTH'(b_q);
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else if (one_available_i) begin
            // fifo_re_o is registered, so it is raised on entry to READ.
            re_d    = 1'b1;
            state_d = S_READ;
          end else begin
            state_d = S_CHECK;
          end
        end
        S_READ: begin
          state_d = S_CAPT;
        end
        S_CAPT: begin
          acc_d   = acc_q | (AW'(fifo_data_i) << cnt_q);
          cnt_d   = cnt_q + CWIDTH'(DWIDTH);
          state_d = S_CHECK;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      b_q     <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      re_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      b_q     <= b_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      re_q    <= re_d;
    end
  end

  assign fifo_re_o    = re_q;
  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign busy_o       = (state_q != S_IDLE);
  assign bits_avail_o = cnt_q;

endmodule

// File: tb/tb_const_bit_extractor.sv
// Self-checking bench for const_bit_extractor: directed corner sequences, a vector
// table, and random requests against a bit-stream reference model.
module tb_const_bit_extractor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        one_available_i = 1'b0;
  logic        two_available_i = 1'b0;
  logic [7:0]  fifo_data_i = 8'h00;
  logic        fifo_re_o;
  logic        req_i = 1'b0;
  logic [3:0]  bits_i = 4'd0;
  logic        flush_i = 1'b0;
  logic [14:0] data_o;
  logic        valid_o;
  logic        busy_o;
  logic [4:0]  bits_avail_o;

  int n_tests = 0;
  int n_fail = 0;
  int re_count = 0;
  int valid_count = 0;
  logic [7:0] fifo_q[$];

  const_bit_extractor dut (
    .clk(clk), .reset(reset), .one_available_i(one_available_i),
    .two_available_i(two_available_i), .fifo_data_i(fifo_data_i),
    .fifo_re_o(fifo_re_o), .req_i(req_i), .bits_i(bits_i), .flush_i(flush_i),
    .data_o(data_o), .valid_o(valid_o), .busy_o(busy_o), .bits_avail_o(bits_avail_o)
  );

  always #5 clk = ~clk;

  // FIFO model: a read pulse presents the next word for the following cycle.
  always @(negedge clk) begin
    if (fifo_re_o) begin
      re_count++;
      if (fifo_q.size() > 0) fifo_data_i = fifo_q.pop_front();
    end
    if (valid_o) valid_count++;
    one_available_i = (fifo_q.size() != 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_req(input int b, input logic [31:0] exp_data, input int exp_avail,
                        input int exp_reads, input int exp_lat, input string tag);
    int r0;
    int cyc;
    @(negedge clk);
    r0 = re_count;
    req_i = 1'b1;
    bits_i = 4'(b);
    @(negedge clk);
    req_i = 1'b0;
    cyc = 1;
    while (!valid_o && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, " data"}, 32'(data_o), exp_data);
    check({tag, " avail"}, 32'(bits_avail_o), 32'(exp_avail));
    check({tag, " reads"}, 32'(re_count - r0), 32'(exp_reads));
    @(negedge clk);
    check({tag, " valid pulse"}, 32'(valid_o), 32'd0);
  endtask

  task automatic do_flush(input string tag);
    @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check({tag, " flush avail"}, 32'(bits_avail_o), 32'd0);
    check({tag, " flush busy"}, 32'(busy_o), 32'd0);
  endtask

  typedef struct {
    int          n_push;
    logic [15:0] bytes;
    int          b;
    logic [14:0] exp_data;
    int          exp_avail;
    int          exp_reads;
    int          exp_lat;
  } vec_t;

  vec_t vecs[9];
  bit   ref_acc[$];
  logic [7:0] ref_fifo[$];

  initial begin
    int v0, r0, busy_low, cyc, b, reads;
    logic [7:0]  byte_v;
    logic [31:0] exp_d;

    vecs[0] = '{1, 16'h00A5, 4, 15'h0005, 4, 1, 5};
    vecs[1] = '{0, 16'h0000, 4, 15'h000A, 0, 0, 2};
    vecs[2] = '{2, 16'h1234, 12, 15'h0234, 4, 2, 8};
    vecs[3] = '{0, 16'h0000, 4, 15'h0001, 0, 0, 2};
    vecs[4] = '{1, 16'h000B, 5, 15'h000B, 3, 1, 5};
    vecs[5] = '{0, 16'h0000, 0, 15'h0000, 3, 0, 2};
    vecs[6] = '{0, 16'h0000, 3, 15'h0000, 0, 0, 2};
    vecs[7] = '{2, 16'h7FFF, 15, 15'h7FFF, 1, 2, 8};
    vecs[8] = '{0, 16'h0000, 1, 15'h0000, 0, 0, 2};

    repeat (3) @(negedge clk);
    check("reset data", 32'(data_o), 32'd0);
    check("reset valid", 32'(valid_o), 32'd0);
    check("reset re", 32'(fifo_re_o), 32'd0);
    check("reset avail", 32'(bits_avail_o), 32'd0);
    check("reset busy", 32'(busy_o), 32'd0);
    reset = 1'b0;

    // Stall on an empty FIFO; a request while busy must be ignored.
    v0 = valid_count;
    r0 = re_count;
    busy_low = 0;
    @(negedge clk);
    req_i = 1'b1;
    bits_i = 4'd15;
    @(negedge clk);
    req_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin req_i = 1'b1; bits_i = 4'd2; end
      if (i == 6) req_i = 1'b0;
      @(negedge clk);
      if (!busy_o) busy_low++;
    end
    check("stall busy", 32'(busy_low), 32'd0);
    check("stall no read", 32'(re_count - r0), 32'd0);
    fifo_q.push_back(8'hFF);
    fifo_q.push_back(8'h7F);
    cyc = 0;
    while (!valid_o && cyc < 50) begin @(negedge clk); cyc++; end
    check("stall data", 32'(data_o), 32'h7FFF);
    check("stall avail", 32'(bits_avail_o), 32'd1);
    repeat (6) @(negedge clk);
    check("busy req ignored", 32'(valid_count - v0), 32'd1);
    check("busy req idle", 32'(busy_o), 32'd0);
    do_flush("stall");

    // Flush while a word is being read.
    fifo_q.push_back(8'hE0);
    do_req(3, 32'h0, 5, 1, 5, "pre-flush");
    fifo_q.push_back(8'hAA);
    v0 = valid_count;
    @(negedge clk);
    req_i = 1'b1;
    bits_i = 4'd8;
    @(negedge clk);
    req_i = 1'b0;
    cyc = 0;
    while (!fifo_re_o && cyc < 20) begin @(negedge clk); cyc++; end
    check("reach READ", 32'(fifo_re_o), 32'd1);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check("flush READ avail", 32'(bits_avail_o), 32'd0);
    check("flush READ busy", 32'(busy_o), 32'd0);
    repeat (4) @(negedge clk);
    check("flush READ no valid", 32'(valid_count - v0), 32'd0);
    fifo_q.push_back(8'h06);
    do_req(3, 32'h6, 5, 1, 5, "post-flush");
    do_flush("post-flush");

    // Asynchronous reset during CAPT.
    fifo_q.push_back(8'h03);
    do_req(2, 32'h3, 6, 1, 5, "pre-reset");
    fifo_q.push_back(8'h55);
    @(negedge clk);
    req_i = 1'b1;
    bits_i = 4'd15;
    @(negedge clk);
    req_i = 1'b0;
    cyc = 0;
    while (!fifo_re_o && cyc < 20) begin @(negedge clk); cyc++; end
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("capt reset data", 32'(data_o), 32'd0);
    check("capt reset valid", 32'(valid_o), 32'd0);
    check("capt reset re", 32'(fifo_re_o), 32'd0);
    check("capt reset avail", 32'(bits_avail_o), 32'd0);
    check("capt reset busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    fifo_q.push_back(8'h01);
    do_req(1, 32'h1, 7, 1, 5, "post-reset");
    do_flush("post-reset");

    for (int i = 0; i < 9; i++) begin
      for (int j = 0; j < vecs[i].n_push; j++) fifo_q.push_back(vecs[i].bytes[8*j +: 8]);
      do_req(vecs[i].b, 32'(vecs[i].exp_data), vecs[i].exp_avail, vecs[i].exp_reads,
             vecs[i].exp_lat, $sformatf("vec%0d", i));
    end
    do_flush("table");

    // Random requests against a bit-stream reference.
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        do_flush("rand");
        ref_acc.delete();
      end
      b = int'($urandom_range(0, 15));
      while (ref_acc.size() + 8 * ref_fifo.size() < b || $urandom_range(0, 3) == 0) begin
        byte_v = 8'($urandom);
        fifo_q.push_back(byte_v);
        ref_fifo.push_back(byte_v);
        if (ref_fifo.size() > 4) break;
      end
      reads = 0;
      while (ref_acc.size() < b) begin
        byte_v = ref_fifo.pop_front();
        for (int k = 0; k < 8; k++) ref_acc.push_back(byte_v[k]);
        reads++;
      end
      exp_d = 32'd0;
      for (int k = 0; k < b; k++) exp_d[k] = ref_acc.pop_front();
      do_req(b, exp_d, ref_acc.size(), reads, 2 + 3 * reads, $sformatf("rand%0d b=%0d", n, b));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
